// File: rtl/stage4_msg_assemble_pkg.sv
// Shared stage-4/stage-5 constants: message geometry, type bytes and slot mux codes.
package stage4_msg_assemble_pkg;

    localparam int DATA_W        = 64;
    localparam int MSG_BITS      = 512;
    localparam int WORDS_PER_MSG = MSG_BITS / DATA_W;
    localparam int CTRL_W        = 3;

    localparam logic [7:0] TYPE_K = 8'h4B;
    localparam logic [7:0] TYPE_T = 8'h54;

    typedef enum logic [CTRL_W-1:0] {
        MUX_NONE  = 3'd0,
        MUX_K     = 3'd1,
        MUX_T     = 3'd2,
        MUX_OTHER = 3'd3
    } mux_ctrl_e;

    function automatic mux_ctrl_e classify(input logic [7:0] type_byte);
        case (type_byte)
            TYPE_K:  return MUX_K;
            TYPE_T:  return MUX_T;
            default: return MUX_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/stage4_word_packer.sv
// Word-to-message packer: sop/eop framing FSM, word counter and MSB-first shift-in.
// msg_done, msg_data and err_pulse are combinational in the cycle of the deciding word.
module stage4_word_packer
    import stage4_msg_assemble_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                in_sop,
    input  logic                in_eop,
    input  logic [DATA_W-1:0]   in_data,
    output logic                msg_done,
    output logic [MSG_BITS-1:0] msg_data,
    output logic                err_pulse
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

    localparam int             CNT_W    = $clog2(WORDS_PER_MSG) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORDS_PER_MSG);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MSG_BITS-1:0] shift_q;
    logic                shift_en;

    // After the eighth shift, word 0 sits in the top DATA_W bits.
    assign msg_data = {shift_q[MSG_BITS-DATA_W-1:0], in_data};

    // NOTE: combinational logic uses blocking '=' with every output defaulted first,
    // so later lines can refine earlier ones and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        msg_done  = 1'b0;
        err_pulse = 1'b0;
        shift_en  = 1'b0;
        if (in_valid) begin
            if (in_sop) begin
                // sop always restarts; it is an error only when it aborts a message in progress
                shift_en  = 1'b1;
                cnt_d     = CNT_W'(1);
                state_d   = ST_COLLECT;
                err_pulse = (state_q == ST_COLLECT);
                if (in_eop) begin
                    err_pulse = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end
            end else begin
                case (state_q)
                    ST_COLLECT: begin
                        shift_en = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                        if (in_eop) begin
                            msg_done  = (cnt_d == FULL_CNT);
                            err_pulse = !msg_done;
                            state_d   = ST_IDLE;
                            cnt_d     = '0;
                        end else if (cnt_d == FULL_CNT) begin
                            err_pulse = 1'b1;
                            state_d   = ST_DROP;
                            cnt_d     = '0;
                        end
                    end
                    ST_DROP: begin
                        if (in_eop) state_d = ST_IDLE;
                    end
                    default: err_pulse = 1'b1;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: pure datapath storage has no reset; the FSM decides when its contents are meaningful.
    always_ff @(posedge clk) begin
        if (shift_en) shift_q <= msg_data;
    end

endmodule

// File: rtl/stage4_msg_assemble.sv
// Stage 4: packs words into messages, batches up to three and strobes them to stage 5.
// Optional macro STAGE4_STATS_EN adds stat_msgs/stat_errs wrapping counters.
module stage4_msg_assemble
    import stage4_msg_assemble_pkg::*;
#(
    parameter int FLUSH_CYCLES = 16
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                in_sop,
    input  logic                in_eop,
    input  logic [DATA_W-1:0]   in_data,
    output logic                message_en,
    output logic [MSG_BITS-1:0] message_1,
    output logic [MSG_BITS-1:0] message_2,
    output logic [MSG_BITS-1:0] message_3,
    output logic [CTRL_W-1:0]   message_mux_control_m1,
    output logic [CTRL_W-1:0]   message_mux_control_m2,
    output logic [CTRL_W-1:0]   message_mux_control_m3,
    output logic                err_pulse
`ifdef STAGE4_STATS_EN
    ,
    output logic [31:0]         stat_msgs,
    output logic [31:0]         stat_errs
`endif
);

    localparam int TIMER_W = $clog2(FLUSH_CYCLES);
    // Issue on the edge where the timer would reach FLUSH_CYCLES-1, so message_en
    // rises exactly FLUSH_CYCLES cycles after the last completion.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FLUSH_CYCLES - 2);

    logic                msg_done;
    logic [MSG_BITS-1:0] msg_data;

    logic [1:0]          slot_cnt;
    logic [TIMER_W-1:0]  flush_timer;
    logic [MSG_BITS-1:0] bank_q [2];

    logic                issue_full, flush_expire, batch_issue;
    logic [2:0]          slot_used;
    logic [MSG_BITS-1:0] slot_data [3];
    logic [CTRL_W-1:0]   slot_ctrl [3];

    stage4_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_data   (in_data),
        .msg_done  (msg_done),
        .msg_data  (msg_data),
        .err_pulse (err_pulse)
    );

    // A completion always beats timer expiry, so a flush never coincides with msg_done.
    assign issue_full   = msg_done && (slot_cnt == 2'd2);
    assign flush_expire = (slot_cnt != 2'd0) && !msg_done && (flush_timer == TIMER_LAST);
    assign batch_issue  = issue_full || flush_expire;

    assign slot_used = {issue_full, slot_cnt == 2'd2, slot_cnt != 2'd0};

    always_comb begin
        slot_data[0] = slot_used[0] ? bank_q[0] : '0;
        slot_data[1] = slot_used[1] ? bank_q[1] : '0;
        slot_data[2] = slot_used[2] ? msg_data  : '0;
        for (int k = 0; k < 3; k++) begin
            slot_ctrl[k] = slot_used[k] ? classify(slot_data[k][MSG_BITS-1 -: 8]) : MUX_NONE;
        end
    end

    // The third message goes straight to the outputs, so the bank only holds two.
    always_ff @(posedge clk) begin
        if (msg_done && !issue_full) bank_q[slot_cnt[0]] <= msg_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt               <= '0;
            flush_timer            <= '0;
            message_en             <= 1'b0;
            message_1              <= '0;
            message_2              <= '0;
            message_3              <= '0;
            message_mux_control_m1 <= MUX_NONE;
            message_mux_control_m2 <= MUX_NONE;
            message_mux_control_m3 <= MUX_NONE;
        end else begin
            message_en <= batch_issue;
            if (batch_issue) begin
                message_1              <= slot_data[0];
                message_2              <= slot_data[1];
                message_3              <= slot_data[2];
                message_mux_control_m1 <= slot_ctrl[0];
                message_mux_control_m2 <= slot_ctrl[1];
                message_mux_control_m3 <= slot_ctrl[2];
                slot_cnt               <= '0;
                flush_timer            <= '0;
            end else if (msg_done) begin
                slot_cnt    <= slot_cnt + 1'b1;
                flush_timer <= '0;
            end else if (slot_cnt != 2'd0) begin
                flush_timer <= flush_timer + 1'b1;
            end
        end
    end

`ifdef STAGE4_STATS_EN
    logic [1:0] issue_msgs;
    assign issue_msgs = issue_full ? 2'd3 : slot_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_msgs <= '0;
            stat_errs <= '0;
        end else begin
            if (batch_issue) stat_msgs <= stat_msgs + 32'(issue_msgs);
            stat_errs <= stat_errs + 32'(err_pulse);
        end
    end
`endif

endmodule

// File: tb/tb_stage4_msg_assemble.sv
// Directed self-checking bench for stage4_msg_assemble (default build, stats disabled).
module tb_stage4_msg_assemble;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_sop, in_eop;
    logic [63:0]  in_data;
    logic         message_en, err_pulse;
    logic [511:0] message_1, message_2, message_3;
    logic [2:0]   m1, m2, m3;

    int checks = 0, errors = 0;
    int cyc = 0, en_cnt = 0, en_cyc = -1, err_cnt = 0, err_cyc = -1, last_eop = -1;

    stage4_msg_assemble dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_valid               (in_valid),
        .in_sop                 (in_sop),
        .in_eop                 (in_eop),
        .in_data                (in_data),
        .message_en             (message_en),
        .message_1              (message_1),
        .message_2              (message_2),
        .message_3              (message_3),
        .message_mux_control_m1 (m1),
        .message_mux_control_m2 (m2),
        .message_mux_control_m3 (m3),
        .err_pulse              (err_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word(input logic [7:0] typ, input logic [7:0] seed, input int n);
        logic [7:0] hdr;
        hdr  = (n == 0) ? typ : 8'hA5;
        word = {hdr, seed, 8'(n), 40'h12_3456_789A};
    endfunction

    function automatic logic [511:0] exp_msg(input logic [7:0] typ, input logic [7:0] seed);
        exp_msg = '0;
        for (int n = 0; n < 8; n++) exp_msg[511 - 64*n -: 64] = word(typ, seed, n);
    endfunction

    // One clock: drive at posedge+1, observe strobes at negedge.
    task automatic tick(input logic v, input logic s, input logic e, input logic [63:0] d);
        in_valid = v; in_sop = s; in_eop = e; in_data = d;
        @(negedge clk);
        if (err_pulse === 1'b1) begin err_cnt++; err_cyc = cyc; end
        if (message_en === 1'b1) begin en_cnt++; en_cyc = cyc; end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic send_msg(input logic [7:0] typ, input logic [7:0] seed, input int nwords, input int eop_at);
        for (int i = 0; i < nwords; i++) begin
            if (i == eop_at) last_eop = cyc;
            tick(1'b1, i == 0, i == eop_at, word(typ, seed, i));
        end
    endtask

    initial begin
        int n0, e0, t0, eop_h;
        logic [63:0] w0;
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_en", 512'(message_en), 512'(0));
        check("reset_msg1", message_1, 512'(0));
        check("reset_ctrl", 512'({m1, m2, m3}), 512'(0));
        check("reset_err", 512'(err_pulse), 512'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full batch of three back-to-back messages
        n0 = en_cnt; e0 = err_cnt;
        send_msg(8'h4B, 8'h01, 8, 7);
        send_msg(8'h54, 8'h02, 8, 7);
        send_msg(8'h00, 8'h03, 8, 7);
        idle(1);
        check("full_en_cnt", 512'(en_cnt - n0), 512'(1));
        check("full_en_lat", 512'(en_cyc), 512'(last_eop + 1));
        check("full_ctrl", 512'({m1, m2, m3}), 512'({3'd1, 3'd2, 3'd3}));
        w0 = word(8'h4B, 8'h01, 0);
        check("full_m1_word0", 512'(message_1[511:448]), 512'(w0));
        check("full_msg1", message_1, exp_msg(8'h4B, 8'h01));
        check("full_msg2", message_2, exp_msg(8'h54, 8'h02));
        check("full_msg3", message_3, exp_msg(8'h00, 8'h03));
        idle(20);
        check("full_hold_en", 512'(en_cnt - n0), 512'(1));
        check("full_hold_msg1", message_1, exp_msg(8'h4B, 8'h01));
        check("full_err", 512'(err_cnt - e0), 512'(0));

        // Single message flushed by the idle timer
        n0 = en_cnt;
        send_msg(8'h4B, 8'h04, 8, 7);
        idle(20);
        check("flush_en_cnt", 512'(en_cnt - n0), 512'(1));
        check("flush_en_lat", 512'(en_cyc), 512'(last_eop + 16));
        check("flush_ctrl", 512'({m1, m2, m3}), 512'({3'd1, 3'd0, 3'd0}));
        check("flush_msg1", message_1, exp_msg(8'h4B, 8'h04));
        check("flush_msg2", message_2, 512'(0));
        check("flush_msg3", message_3, 512'(0));

        // Early eop: error, no slot consumed
        n0 = en_cnt; e0 = err_cnt;
        send_msg(8'h4B, 8'h05, 6, 5);
        check("early_err_cyc", 512'(err_cyc), 512'(last_eop));
        send_msg(8'h54, 8'h06, 8, 7);
        idle(20);
        check("early_err_cnt", 512'(err_cnt - e0), 512'(1));
        check("early_en_cnt", 512'(en_cnt - n0), 512'(1));
        check("early_ctrl", 512'({m1, m2, m3}), 512'({3'd2, 3'd0, 3'd0}));
        check("early_msg1", message_1, exp_msg(8'h54, 8'h06));

        // Overlong message: nine words without eop, then eop, then a good message
        n0 = en_cnt; e0 = err_cnt; t0 = cyc;
        send_msg(8'h4B, 8'h0F, 9, -1);
        tick(1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0000);
        check("long_err_cyc", 512'(err_cyc), 512'(t0 + 7));
        send_msg(8'h4B, 8'h07, 8, 7);
        idle(20);
        check("long_err_cnt", 512'(err_cnt - e0), 512'(1));
        check("long_en_cnt", 512'(en_cnt - n0), 512'(1));
        check("long_ctrl", 512'({m1, m2, m3}), 512'({3'd1, 3'd0, 3'd0}));
        check("long_msg1", message_1, exp_msg(8'h4B, 8'h07));

        // Completion on the flush-expiry cycle joins the batch instead
        n0 = en_cnt;
        send_msg(8'h4B, 8'h08, 8, 7);
        eop_h = last_eop;
        idle(7);
        send_msg(8'h54, 8'h09, 8, 7);
        idle(20);
        check("race_eop_cyc", 512'(last_eop - eop_h), 512'(15));
        check("race_en_cnt", 512'(en_cnt - n0), 512'(1));
        check("race_en_lat", 512'(en_cyc), 512'(last_eop + 16));
        check("race_ctrl", 512'({m1, m2, m3}), 512'({3'd1, 3'd2, 3'd0}));
        check("race_msg1", message_1, exp_msg(8'h4B, 8'h08));
        check("race_msg2", message_2, exp_msg(8'h54, 8'h09));
        check("race_msg3", message_3, 512'(0));

        // Reset mid-message with two slots filled
        n0 = en_cnt;
        send_msg(8'h4B, 8'h0A, 8, 7);
        send_msg(8'h54, 8'h0B, 8, 7);
        send_msg(8'h4B, 8'h0C, 4, -1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_msg1", message_1, 512'(0));
        check("rst_msg2", message_2, 512'(0));
        check("rst_ctrl", 512'({m1, m2, m3}), 512'(0));
        idle(2);
        rst_n = 1'b1;
        idle(20);
        check("rst_no_en", 512'(en_cnt - n0), 512'(0));
        check("rst_hold_msg1", message_1, 512'(0));
        send_msg(8'h4B, 8'h0D, 8, 7);
        send_msg(8'h54, 8'h0E, 8, 7);
        send_msg(8'h54, 8'h10, 8, 7);
        idle(1);
        check("post_rst_en_cnt", 512'(en_cnt - n0), 512'(1));
        check("post_rst_en_lat", 512'(en_cyc), 512'(last_eop + 1));
        check("post_rst_ctrl", 512'({m1, m2, m3}), 512'({3'd1, 3'd2, 3'd2}));
        check("post_rst_msg1", message_1, exp_msg(8'h4B, 8'h0D));
        check("post_rst_msg3", message_3, exp_msg(8'h54, 8'h10));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
